prga: RTL and testbench

- Pseudo-random generation stage of the ARC4 datapath; runs directly downstream of the key-scheduling stage.
- Consumes the permuted state array S left in S-RAM by key scheduling and reads the length-prefixed ciphertext from CT-RAM.
- Writes the length-prefixed plaintext to PT-RAM, updating S in place per the ARC4 PRGA.
- Feeds the top-level cracker, which inspects the plaintext and the `valid` flag.

---
 rtl/arc4_pkg.sv | 37 +++
 rtl/prga.sv | 182 ++++++++++++++++++
 tb/tb_prga.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
//------------------------------------------------------------------------------
// arc4_pkg : shared types, constants and helpers for the ARC4 datapath stages.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    PRGA_IDLE   = 4'd0,
    PRGA_RD_LEN = 4'd1,
    PRGA_WT_LEN = 4'd2,
    PRGA_WR_LEN = 4'd3,
    PRGA_RD_SI  = 4'd4,
    PRGA_WT_SI  = 4'd5,
    PRGA_RD_SJ  = 4'd6,
    PRGA_WT_SJ  = 4'd7,
    PRGA_WR_SI  = 4'd8,
    PRGA_WR_SJ  = 4'd9,
    PRGA_RD_PAD = 4'd10,
    PRGA_WT_PAD = 4'd11,
    PRGA_WR_PT  = 4'd12,
    PRGA_DONE   = 4'd13
  } prga_state_e;

  localparam byte_t PRINT_LO = 8'h20;
  localparam byte_t PRINT_HI = 8'h7E;

  function automatic logic is_printable(input byte_t b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prga.sv
//------------------------------------------------------------------------------
// prga : ARC4 pseudo-random generation stage (S-RAM in place, CT-RAM -> PT-RAM).
//        Optional printable-plaintext check with early abort: PRGA_CHECK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic       valid
);

  prga_state_e state_q;
  byte_t       i_q, j_q, si_q, sj_q, len_q;
  logic [8:0]  k_q;
  byte_t       s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
  logic        rdy_q, s_wren_q, pt_wren_q;

  byte_t       pt_byte_d;
  byte_t       j_d;
  logic        last_d;

  assign pt_byte_d = s_rddata ^ ct_rddata;
  assign j_d       = j_q + s_rddata;
  assign last_d    = (k_q == {1'b0, len_q});

`ifdef PRGA_CHECK_EN
  logic valid_q;
  logic bad_q;
  assign valid = valid_q;
`else
  assign valid = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PRGA_IDLE;
      rdy_q       <= 1'b1;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      len_q       <= '0;
      k_q         <= '0;
      s_addr_q    <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
`ifdef PRGA_CHECK_EN
      valid_q     <= 1'b1;
      bad_q       <= 1'b0;
`endif
    end else begin
      s_wren_q  <= 1'b0;
      pt_wren_q <= 1'b0;
      case (state_q)
        PRGA_IDLE: begin
          if (en) begin
            state_q   <= PRGA_RD_LEN;
            rdy_q     <= 1'b0;
            ct_addr_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
`ifdef PRGA_CHECK_EN
            valid_q   <= 1'b1;
            bad_q     <= 1'b0;
`endif
          end
        end
        PRGA_RD_LEN: state_q <= PRGA_WT_LEN;
        PRGA_WT_LEN: begin
          state_q     <= PRGA_WR_LEN;
          len_q       <= ct_rddata;
          pt_addr_q   <= '0;
          pt_wrdata_q <= ct_rddata;
          pt_wren_q   <= 1'b1;
          k_q         <= 9'd1;
          i_q         <= 8'd1;
        end
        PRGA_WR_LEN: begin
          if (len_q == 8'd0) begin
            state_q <= PRGA_DONE;
            rdy_q   <= 1'b1;
          end else begin
            state_q  <= PRGA_RD_SI;
            s_addr_q <= i_q;
          end
        end
        PRGA_RD_SI: state_q <= PRGA_WT_SI;
        PRGA_WT_SI: begin
          state_q  <= PRGA_RD_SJ;
          si_q     <= s_rddata;
          j_q      <= j_d;
          s_addr_q <= j_d;
        end
        PRGA_RD_SJ: state_q <= PRGA_WT_SJ;
        PRGA_WT_SJ: begin
          state_q    <= PRGA_WR_SI;
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
        end
        // S[j] is written last so that i==j leaves the original value in place
        PRGA_WR_SI: begin
          state_q    <= PRGA_WR_SJ;
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
        end
        PRGA_WR_SJ: begin
          state_q   <= PRGA_RD_PAD;
          s_addr_q  <= si_q + sj_q;
          ct_addr_q <= k_q[7:0];
        end
        PRGA_RD_PAD: state_q <= PRGA_WT_PAD;
        PRGA_WT_PAD: begin
          state_q     <= PRGA_WR_PT;
          pt_addr_q   <= k_q[7:0];
          pt_wrdata_q <= pt_byte_d;
          pt_wren_q   <= 1'b1;
`ifdef PRGA_CHECK_EN
          bad_q       <= !is_printable(pt_byte_d);
`endif
        end
        PRGA_WR_PT: begin
`ifdef PRGA_CHECK_EN
          if (last_d || bad_q) begin
            state_q <= PRGA_DONE;
            rdy_q   <= 1'b1;
            if (bad_q) valid_q <= 1'b0;
          end else begin
`else
          if (last_d) begin
            state_q <= PRGA_DONE;
            rdy_q   <= 1'b1;
          end else begin
`endif
            state_q  <= PRGA_RD_SI;
            k_q      <= k_q + 9'd1;
            i_q      <= i_q + 8'd1;
            s_addr_q <= i_q + 8'd1;
          end
        end
        PRGA_DONE: state_q <= PRGA_IDLE;
        default: begin
          state_q <= PRGA_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

`default_nettype wire

// File: tb/tb_prga.sv
//------------------------------------------------------------------------------
// tb_prga : self-checking bench for prga against a plain ARC4 PRGA model.
//           Expectations follow PRGA_CHECK_EN when it is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
  logic       valid;

  int checks = 0;
  int errors = 0;

  prga dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  // Synchronous memories; load copies the staged images in one clock
  logic [7:0] s_mem [256];
  logic [7:0] ct_mem[256];
  logic [7:0] pt_mem[256];
  logic [7:0] s_init [256];
  logic [7:0] ct_init[256];
  logic       load = 1'b0;
  int         s_wr_cnt = 0;
  int         pt_wr_cnt = 0;

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 256; a++) begin
        s_mem[a]  <= s_init[a];
        ct_mem[a] <= ct_init[a];
        pt_mem[a] <= 8'hEE;
      end
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_cnt      <= s_wr_cnt + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_wr_cnt       <= pt_wr_cnt + 1;
      end
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
  end

  // Reference results
  logic [7:0] exp_s [256];
  logic [7:0] exp_pt[256];
  int         exp_bytes;
  logic       exp_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model();
    int         i, j, len;
    logic [7:0] si, sj, b;
    i = 0; j = 0;
    len = int'(ct_init[0]);
    for (int a = 0; a < 256; a++) begin
      exp_s[a]  = s_init[a];
      exp_pt[a] = 8'hEE;
    end
    exp_pt[0] = ct_init[0];
    exp_bytes = len;
    exp_valid = 1'b1;
    for (int k = 1; k <= len; k++) begin
      i  = (i + 1) % 256;
      si = exp_s[i];
      j  = (j + int'(si)) % 256;
      sj = exp_s[j];
      exp_s[i] = sj;
      exp_s[j] = si;
      b = exp_s[(int'(si) + int'(sj)) % 256] ^ ct_init[k];
      exp_pt[k] = b;
`ifdef PRGA_CHECK_EN
      if (b < 8'h20 || b > 8'h7E) begin
        exp_valid = 1'b0;
        exp_bytes = k;
        break;
      end
`endif
    end
  endtask

  task automatic do_load();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic identity_s();
    for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
  endtask

  task automatic random_s();
    logic [7:0] t;
    int         b;
    identity_s();
    for (int a = 255; a > 0; a--) begin
      b = int'($urandom_range(a, 0));
      t = s_init[a]; s_init[a] = s_init[b]; s_init[b] = t;
    end
  endtask

  task automatic random_ct(input int len);
    for (int a = 0; a < 256; a++) ct_init[a] = 8'($urandom);
    ct_init[0] = len[7:0];
  endtask

  // Start a run, optionally waving en while busy, and check every result
  task automatic run_and_check(input string name, input int en_noise, output int cyc);
    int sw0, pw0;
    model();
    do_load();
    @(negedge clk);
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    cyc = 1;
    check({name, ".busy"}, 32'(rdy), 32'd0);
    while (!rdy && cyc < 3000) begin
      en = (en_noise > 0 && cyc >= 3 && cyc < 3 + en_noise);
      @(negedge clk);
      cyc++;
    end
    en = 1'b0;
    check({name, ".done_in_time"}, 32'(rdy), 32'd1);
    check({name, ".latency"}, 32'(cyc), 32'(4 + 9 * exp_bytes));
    check({name, ".valid"}, 32'(valid), 32'(exp_valid));
    check({name, ".s_writes"}, 32'(s_wr_cnt - sw0), 32'(2 * exp_bytes));
    check({name, ".pt_writes"}, 32'(pt_wr_cnt - pw0), 32'(exp_bytes + 1));
    for (int a = 0; a < 256; a++) begin
      check($sformatf("%s.pt[%0d]", name, a), 32'(pt_mem[a]), 32'(exp_pt[a]));
      check($sformatf("%s.S[%0d]", name, a), 32'(s_mem[a]), 32'(exp_s[a]));
    end
    @(negedge clk);
    check({name, ".idle_rdy"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    int         cyc;
    int         jj;
    logic [7:0] t;
    logic [7:0] key [3];

    rst_n = 1'b0;
    en    = 1'b0;
    identity_s();
    for (int a = 0; a < 256; a++) ct_init[a] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset.rdy", 32'(rdy), 32'd1);
    check("reset.valid", 32'(valid), 32'd1);
    check("reset.s_wren", 32'(s_wren), 32'd0);
    check("reset.pt_wren", 32'(pt_wren), 32'd0);
    check("reset.addrs", {s_addr, ct_addr, pt_addr, 8'h00}, 32'd0);
    check("reset.wrdata", {16'h0, s_wrdata, pt_wrdata}, 32'd0);
    rst_n = 1'b1;

    // Identity S, two-byte message
    identity_s();
    random_ct(2);
    ct_init[1] = 8'h41; ct_init[2] = 8'h42;
    run_and_check("ident2", 0, cyc);
    check("ident2.lat22", 32'(cyc), 32'd22);
    check("ident2.pt1", 32'(pt_mem[1]), 32'h43);
    check("ident2.pt2", 32'(pt_mem[2]), 32'h47);
    check("ident2.S2S3", {16'h0, s_mem[2], s_mem[3]}, 32'h0302);

    // Empty message
    identity_s();
    random_ct(0);
    run_and_check("len0", 0, cyc);
    check("len0.lat4", 32'(cyc), 32'd4);

    // Printable-check stimulus: first plaintext byte is 0x00
    identity_s();
    random_ct(3);
    ct_init[1] = 8'h02; ct_init[2] = 8'h41; ct_init[3] = 8'h41;
    run_and_check("chk", 0, cyc);
    check("chk.pt1", 32'(pt_mem[1]), 32'h00);
`ifdef PRGA_CHECK_EN
    check("chk.valid0", 32'(valid), 32'd0);
    check("chk.no_pt2", 32'(pt_mem[2]), 32'hEE);
`else
    check("chk.valid1", 32'(valid), 32'd1);
    check("chk.lat31", 32'(cyc), 32'd31);
`endif

    // S left by key scheduling with key 00 00 18, full-length message
    key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
    identity_s();
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(s_init[a]) + int'(key[a % 3])) % 256;
      t = s_init[a]; s_init[a] = s_init[jj]; s_init[jj] = t;
    end
    random_ct(255);
    run_and_check("ksa255", 0, cyc);

    // Random permutations and messages, en waved while busy on one of them
    for (int r = 0; r < 3; r++) begin
      random_s();
      random_ct(int'($urandom_range(40, 3)));
      run_and_check($sformatf("rnd%0d", r), (r == 1) ? 8 : 0, cyc);
    end

    // Reset in the middle of a long run, then a fresh run
    random_s();
    random_ct(200);
    do_load();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.rdy", 32'(rdy), 32'd1);
    check("midrst.wren", {30'd0, s_wren, pt_wren}, 32'd0);
    check("midrst.valid", 32'(valid), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    random_s();
    random_ct(20);
    run_and_check("afterrst", 0, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
